// File: rtl/cnu_pipe_cell.sv
// cnu_pipe_cell: four-stage min-sum check-node update (capture, search, normalise, update).
// Optional macro CNU_SAT_EN selects saturating arithmetic; without it arithmetic wraps mod 2^D_WID.
module cnu_pipe_cell #(
  parameter int D_WID = 8,
  parameter int DEG   = 6,
  parameter int IDX_W = 3,
  parameter int LR_W  = 2*D_WID + IDX_W + 1 + DEG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iter_0,
  input  logic [IDX_W:0]       deg_act,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DEG*D_WID-1:0] lq_in,
  input  logic [LR_W-1:0]      lr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DEG*D_WID-1:0] lq_out,
  output logic [LR_W-1:0]      lr_out
);
  localparam int EXT_W = D_WID + 2;
  typedef logic [D_WID-1:0]        msg_t;
  typedef logic signed [EXT_W-1:0] ext_t;

`ifdef CNU_SAT_EN
  localparam int   SAT_I  = (1 << (D_WID-1)) - 1;
  localparam ext_t SAT_HI = EXT_W'(SAT_I);
  localparam ext_t SAT_LO = EXT_W'(-SAT_I);
`endif

  function automatic ext_t sext(input msg_t v);
    return {{2{v[D_WID-1]}}, v};
  endfunction

  // Lane value of a compressed word: {min1, min2, idx, sxor, sign[0..DEG-1]}.
  function automatic ext_t expand_lr(input logic [LR_W-1:0] w, input int lane);
    msg_t mag;
    ext_t e;
    logic neg;
    mag = (w[DEG+IDX_W -: IDX_W] == IDX_W'(lane)) ? w[LR_W-D_WID-1 -: D_WID] : w[LR_W-1 -: D_WID];
    neg = w[DEG-1-lane] ^ w[DEG];
    e   = {2'b00, mag};
    return neg ? -e : e;
  endfunction

  function automatic msg_t fix(input ext_t v);
`ifdef CNU_SAT_EN
    if (v > SAT_HI) return SAT_HI[D_WID-1:0];
    if (v < SAT_LO) return SAT_LO[D_WID-1:0];
`endif
    return v[D_WID-1:0];
  endfunction

  function automatic msg_t abs_mag(input msg_t v);
    msg_t m;
    m = v[D_WID-1] ? (~v) + msg_t'(1) : v;
`ifdef CNU_SAT_EN
    if (m == {1'b1, {(D_WID-1){1'b0}}}) m = SAT_HI[D_WID-1:0];
`endif
    return m;
  endfunction

  function automatic msg_t scale(input msg_t m);
    logic [D_WID:0] t;
    t = {1'b0, m} + {3'b000, m[D_WID-1:2]} + (D_WID+1)'(1);
    return t[D_WID:1];
  endfunction

  logic                 s1_v_q, s2_v_q, s3_v_q, s4_v_q;
  msg_t                 s1_q_q [DEG];
  msg_t                 s2_q_q [DEG];
  msg_t                 s3_q_q [DEG];
  logic [DEG-1:0]       s1_act_q, s2_act_q, s3_act_q;
  msg_t                 s2_min1_q, s2_min2_q;
  logic [IDX_W-1:0]     s2_idx_q;
  logic                 s2_sxor_q;
  logic [DEG-1:0]       s2_sgn_q;
  logic [LR_W-1:0]      s3_word_q;
  logic [DEG*D_WID-1:0] lq_out_q;
  logic [LR_W-1:0]      lr_out_q;

  // valid/ready: a row moves on a rising edge where valid && ready; a stage loads when it is
  // empty or its successor moves, so in_ready is combinational from out_ready through the chain.
  logic en1, en2, en3, en4;
  assign en4       = !s4_v_q || out_ready;
  assign en3       = !s3_v_q || en4;
  assign en2       = !s2_v_q || en3;
  assign en1       = !s1_v_q || en2;
  assign in_ready  = en1;
  assign out_valid = s4_v_q;
  assign lq_out    = lq_out_q;
  assign lr_out    = lr_out_q;

  logic [IDX_W:0] deg_c;
  logic [DEG-1:0] act_d;
  msg_t           q1_d [DEG];
  always_comb begin
    deg_c = deg_act;
    if (deg_act < (IDX_W+1)'(2))        deg_c = (IDX_W+1)'(2);
    else if (deg_act > (IDX_W+1)'(DEG)) deg_c = (IDX_W+1)'(DEG);
    act_d = '0;
    for (int i = 0; i < DEG; i++) begin
      act_d[i] = ((IDX_W+1)'(i) < deg_c);
      q1_d[i]  = '0;
      if (act_d[i]) begin
        if (iter_0) q1_d[i] = lq_in[(DEG-i)*D_WID-1 -: D_WID];
        else        q1_d[i] = fix(sext(lq_in[(DEG-i)*D_WID-1 -: D_WID]) - expand_lr(lr_in, i));
      end
    end
  end

  // Strict less-than keeps the lowest lane on ties; min2 skips only the winning lane.
  msg_t             mag_d [DEG];
  msg_t             min1_d, min2_d;
  logic [IDX_W-1:0] idx_d;
  logic             sxor_d;
  logic [DEG-1:0]   sgn_d;
  always_comb begin
    min1_d = '1;
    min2_d = '1;
    idx_d  = '0;
    sxor_d = 1'b0;
    sgn_d  = '0;
    for (int i = 0; i < DEG; i++) begin
      mag_d[i] = abs_mag(s1_q_q[i]);
      if (s1_act_q[i]) begin
        sgn_d[DEG-1-i] = s1_q_q[i][D_WID-1];
        sxor_d         = sxor_d ^ s1_q_q[i][D_WID-1];
        if (mag_d[i] < min1_d) begin
          min1_d = mag_d[i];
          idx_d  = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < DEG; i++) begin
      if (s1_act_q[i] && (idx_d != IDX_W'(i)) && (mag_d[i] < min2_d)) min2_d = mag_d[i];
    end
  end

  logic [LR_W-1:0] word_d;
  assign word_d = {scale(s2_min1_q), scale(s2_min2_q), s2_idx_q, s2_sxor_q, s2_sgn_q};

  logic [DEG*D_WID-1:0] lq_d;
  always_comb begin
    lq_d = '0;
    for (int i = 0; i < DEG; i++) begin
      if (s3_act_q[i]) lq_d[(DEG-i)*D_WID-1 -: D_WID] = fix(sext(s3_q_q[i]) + expand_lr(s3_word_q, i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      s4_v_q   <= 1'b0;
      lq_out_q <= '0;
      lr_out_q <= '0;
    end else begin
      if (en4) begin
        s4_v_q <= s3_v_q;
        if (s3_v_q) begin
          lq_out_q <= lq_d;
          lr_out_q <= s3_word_q;
        end
      end
      if (en3) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) begin
          s3_q_q    <= s2_q_q;
          s3_act_q  <= s2_act_q;
          s3_word_q <= word_d;
        end
      end
      if (en2) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_q_q    <= s1_q_q;
          s2_act_q  <= s1_act_q;
          s2_min1_q <= min1_d;
          s2_min2_q <= min2_d;
          s2_idx_q  <= idx_d;
          s2_sxor_q <= sxor_d;
          s2_sgn_q  <= sgn_d;
        end
      end
      if (en1) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_q_q   <= q1_d;
          s1_act_q <= act_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnu_pipe_cell.sv
// Bench for cnu_pipe_cell: directed rows, backpressure, reset flush and random traffic
// scored against an integer reference model through an expected-row queue.
module tb_cnu_pipe_cell;
  localparam int D_WID = 8;
  localparam int DEG   = 6;
  localparam int IDX_W = 3;
  localparam int LR_W  = 2*D_WID + IDX_W + 1 + DEG;
  localparam int LQ_W  = DEG*D_WID;
  localparam int W     = LQ_W + LR_W;
  localparam int SMAX  = (1 << (D_WID-1)) - 1;

  logic            clk, reset, iter_0, in_valid, in_ready, out_valid, out_ready;
  logic [IDX_W:0]  deg_act;
  logic [LQ_W-1:0] lq_in, lq_out;
  logic [LR_W-1:0] lr_in, lr_out;

  cnu_pipe_cell #(.D_WID(D_WID), .DEG(DEG), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .iter_0(iter_0), .deg_act(deg_act),
    .in_valid(in_valid), .in_ready(in_ready), .lq_in(lq_in), .lr_in(lr_in),
    .out_valid(out_valid), .out_ready(out_ready), .lq_out(lq_out), .lr_out(lr_out)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int or_mode  = 1;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // ---- reference model (plain integer arithmetic) ----
  function automatic int limit(input int v);
`ifdef CNU_SAT_EN
    if (v > SMAX)  return SMAX;
    if (v < -SMAX) return -SMAX;
    return v;
`else
    int r;
    r = v & ((1 << D_WID) - 1);
    return (r > SMAX) ? r - (1 << D_WID) : r;
`endif
  endfunction

  function automatic int lane_val(input logic [LQ_W-1:0] v, input int i);
    logic signed [D_WID-1:0] s;
    s = v[(DEG-i)*D_WID-1 -: D_WID];
    return int'(s);
  endfunction

  function automatic int lr_val(input logic [LR_W-1:0] w, input int i);
    int m1, m2, ix, mag;
    logic neg;
    m1  = int'(w[LR_W-1 -: D_WID]);
    m2  = int'(w[LR_W-D_WID-1 -: D_WID]);
    ix  = int'(w[DEG+IDX_W -: IDX_W]);
    mag = (ix == i) ? m2 : m1;
    neg = w[DEG-1-i] ^ w[DEG];
    return neg ? -mag : mag;
  endfunction

  function automatic logic [W-1:0] model(input logic [LQ_W-1:0] lqv, input logic [LR_W-1:0] lrw,
                                         input logic it0, input int dact);
    int dg, m1, m2, ix, v;
    int q[DEG];
    int mag[DEG];
    logic sx;
    logic [DEG-1:0] sg;
    logic [LR_W-1:0] nw;
    logic [LQ_W-1:0] lo;
    dg = (dact < 2) ? 2 : ((dact > DEG) ? DEG : dact);
    sx = 1'b0;
    sg = '0;
    lo = '0;
    for (int i = 0; i < DEG; i++) begin
      q[i]   = 0;
      mag[i] = 0;
      if (i < dg) begin
        v      = lane_val(lqv, i);
        q[i]   = it0 ? v : limit(v - lr_val(lrw, i));
        mag[i] = (q[i] < 0) ? -q[i] : q[i];
`ifdef CNU_SAT_EN
        if (mag[i] > SMAX) mag[i] = SMAX;
`endif
        if (q[i] < 0) begin
          sx = ~sx;
          sg[DEG-1-i] = 1'b1;
        end
      end
    end
    ix = 0;
    for (int i = 1; i < dg; i++) if (mag[i] < mag[ix]) ix = i;
    m2 = -1;
    for (int i = 0; i < dg; i++) if (i != ix && (m2 < 0 || mag[i] < m2)) m2 = mag[i];
    m1 = (mag[ix] + mag[ix]/4 + 1) / 2;
    m2 = (m2 + m2/4 + 1) / 2;
    nw = {D_WID'(m1), D_WID'(m2), IDX_W'(ix), sx, sg};
    for (int i = 0; i < dg; i++) lo[(DEG-i)*D_WID-1 -: D_WID] = D_WID'(limit(q[i] + lr_val(nw, i)));
    return {lo, nw};
  endfunction

  function automatic logic [LQ_W-1:0] pack6(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5);
    return {D_WID'(a0), D_WID'(a1), D_WID'(a2), D_WID'(a3), D_WID'(a4), D_WID'(a5)};
  endfunction

  // ---- driver tasks (called at a falling edge, return at a falling edge) ----
  initial forever begin
    @(negedge clk);
    out_ready = (or_mode == 1) ? 1'b1 : (or_mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic set_mode(input int m);
    @(posedge clk);
    #1;
    or_mode = m;
    @(negedge clk);
  endtask

  task automatic send(input logic [LQ_W-1:0] lqv, input logic [LR_W-1:0] lrw, input logic it0,
                      input logic [IDX_W:0] da, input logic [W-1:0] expv);
    int waited;
    waited   = 0;
    lq_in    = lqv;
    lr_in    = lrw;
    iter_0   = it0;
    deg_act  = da;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout waited=%0d limit=200", waited);
    end else begin
      exp_q.push_back(expv);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rand_row(output logic [LQ_W-1:0] lqv, output logic [LR_W-1:0] lrw,
                          output logic it0, output logic [IDX_W:0] da);
    for (int i = 0; i < DEG; i++) begin
      case ($urandom_range(0, 3))
        0:       lqv[(DEG-i)*D_WID-1 -: D_WID] = D_WID'(int'($urandom_range(0, 14)) - 7);
        1:       lqv[(DEG-i)*D_WID-1 -: D_WID] = {1'b1, {(D_WID-1){1'b0}}};
        default: lqv[(DEG-i)*D_WID-1 -: D_WID] = D_WID'($urandom());
      endcase
    end
    lrw = LR_W'({$urandom(), $urandom()});
    it0 = 1'($urandom_range(0, 1));
    da  = (IDX_W+1)'($urandom_range(0, (1 << (IDX_W+1)) - 1));
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s rows_left=%0d required=0", name, exp_q.size());
    end
  endtask

  // ---- scoreboard monitor: the head row must be presented and held until taken ----
  initial forever begin
    @(negedge clk);
    #2;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_row got=%h required=none", {lq_out, lr_out});
      end else begin
        check(out_ready ? "out_row" : "stall_hold", {lq_out, lr_out}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---- stimulus ----
  initial begin
    logic [LQ_W-1:0] lqv;
    logic [LR_W-1:0] lrw;
    logic            it0;
    logic [IDX_W:0]  da;
    logic [LQ_W-1:0] bp_lq [6];
    logic [LR_W-1:0] bp_lr [6];
    logic            bp_it [6];
    logic [IDX_W:0]  bp_da [6];
    int              acc;

    reset = 1'b1; in_valid = 1'b0; iter_0 = 1'b0; deg_act = '0; lq_in = '0; lr_in = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_outputs", {lq_out, lr_out}, '0);
    @(negedge clk);

    // Basic row; out_valid appears in the fourth cycle after the presenting cycle.
    lq_in = pack6(10, -3, 7, 20, -5, 4); lr_in = '0; iter_0 = 1'b1; deg_act = 4'd6; in_valid = 1'b1;
    #1;
    check("basic_accept", W'(in_ready), W'(1));
    exp_q.push_back({pack6(12, -6, 9, 22, -7, 6), 8'd2, 8'd3, 3'd1, 1'b0, 6'b010010});
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("latency_c%0d", k), W'(out_valid), W'(k == 4));
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);

    send(pack6(5, -5, 5, 5, -5, 5), '0, 1'b1, 4'd6,
         {pack6(8, -8, 8, 8, -8, 8), 8'd3, 8'd3, 3'd0, 1'b0, 6'b010010});
    send(pack6(10, -20, 30, 6, -1, -1), '0, 1'b1, 4'd4,
         {pack6(6, -16, 26, 0, 0, 0), 8'd4, 8'd6, 3'd3, 1'b1, 6'b010000});
`ifdef CNU_SAT_EN
    send(pack6(120, 0, 0, 0, 0, 0), {8'd20, 8'd20, 3'd0, 1'b0, 6'b100000}, 1'b0, 4'd6,
         {pack6(114, -7, -7, -7, -7, -7), 8'd13, 8'd13, 3'd1, 1'b1, 6'b011111});
`else
    send(pack6(120, 0, 0, 0, 0, 0), {8'd20, 8'd20, 3'd0, 1'b0, 6'b100000}, 1'b0, 4'd6,
         {pack6(127, -33, -33, -33, -33, -33), 8'd13, 8'd13, 3'd1, 1'b0, 6'b111111});
`endif
    wait_empty("directed_drain");

    // Backpressure: six rows offered with the sink stalled.
    for (int r = 0; r < 6; r++) begin
      rand_row(lqv, lrw, it0, da);
      bp_lq[r] = lqv; bp_lr[r] = lrw; bp_it[r] = it0; bp_da[r] = da;
    end
    set_mode(0);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      lq_in = bp_lq[acc]; lr_in = bp_lr[acc]; iter_0 = bp_it[acc]; deg_act = bp_da[acc];
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        exp_q.push_back(model(bp_lq[acc], bp_lr[acc], bp_it[acc], int'(bp_da[acc])));
        acc++;
      end
      @(negedge clk);
      if (acc >= 5) break;
    end
    #1;
    check("bp_accepted", W'(acc), W'(4));
    check("bp_in_ready", W'(in_ready), W'(0));
    in_valid = 1'b0;
    set_mode(1);
    for (int r = acc; r < 6; r++)
      send(bp_lq[r], bp_lr[r], bp_it[r], bp_da[r], model(bp_lq[r], bp_lr[r], bp_it[r], int'(bp_da[r])));
    wait_empty("bp_drain");

    // Reset with two rows in flight: nothing may come out afterwards.
    for (int r = 0; r < 2; r++) begin
      rand_row(lqv, lrw, it0, da);
      send(lqv, lrw, it0, da, model(lqv, lrw, it0, int'(da)));
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));
    for (int c = 0; c < 6; c++) begin
      check("post_rst_out_valid", W'(out_valid), W'(0));
      @(negedge clk);
      #1;
    end
    @(negedge clk);

    // Random traffic with random sink stalls.
    set_mode(2);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      rand_row(lqv, lrw, it0, da);
      send(lqv, lrw, it0, da, model(lqv, lrw, it0, int'(da)));
    end
    set_mode(1);
    wait_empty("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
